// File: rtl/dcmi_capture.sv
// DCMI receive front-end: samples camera sync/data, decodes external or embedded
// framing, packs pixels into 32-bit words and manages snapshot/continuous capture.
module dcmi_capture #(
    parameter int DW     = 14,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              capture_en,
    input  logic              snapshot_mode,
    input  logic              embd_sync_en,
    input  logic              vsync_pol,
    input  logic              hsync_pol,
    input  logic [1:0]        data_bus_width,
    input  logic [7:0]        fsc,
    input  logic [7:0]        fec,
    input  logic [7:0]        lsc,
    input  logic [7:0]        lec,
    input  logic [7:0]        fsu,
    input  logic [7:0]        feu,
    input  logic [7:0]        lsu,
    input  logic [7:0]        leu,
    input  logic              vsync,
    input  logic              hsync,
    input  logic [DW-1:0]     data,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              frame_start,
    output logic              frame_end,
    output logic              line_end,
    output logic              sync_err,
    output logic              capture_en_clr,
    output logic [FCNT_W-1:0] frame_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_FS, FRAME} state_t;

    state_t        state_q;
    logic          vs_q, hs_q, vs_prev_q, hs_prev_q;
    logic [DW-1:0] dat_q;
    logic [1:0]    cpos_q, cpos_d;
    logic          cerr_q, cerr_d;
    logic          inline_q, inline_d;
    logic [31:0]   wbuf_q, wbuf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          ov_d, ol_d;
    logic [31:0]   od_d;

    logic          vact, hact, vact_p, hact_p, is_ff, code_xy, code_ok;
    logic          hit_fs, hit_fe, hit_ls, hit_le;
    logic          fs_ev, fe_ev, le_ev, pix_raw, pix, fe_now, in_frame, full;
    logic [7:0]    byte_s;
    logic [15:0]   px16;
    logic [2:0]    slot;

    function automatic logic [15:0] px_mask(input logic [15:0] d, input logic [1:0] w);
        case (w)
            2'd0:    return {8'd0, d[7:0]};
            2'd1:    return {6'd0, d[9:0]};
            2'd2:    return {4'd0, d[11:0]};
            default: return {2'd0, d[13:0]};
        endcase
    endfunction

    function automatic logic [31:0] pack_px(input logic [31:0] w, input logic [2:0] idx,
                                            input logic [15:0] px, input logic b8);
        logic [31:0] r;
        r = w;
        if (b8) begin
            case (idx[1:0])
                2'd0:    r[7:0]   = px[7:0];
                2'd1:    r[15:8]  = px[7:0];
                2'd2:    r[23:16] = px[7:0];
                default: r[31:24] = px[7:0];
            endcase
        end else if (idx[0]) begin
            r[31:16] = px;
        end else begin
            r[15:0] = px;
        end
        return r;
    endfunction

    function automatic logic code_hit(input logic [7:0] xy, input logic [7:0] code,
                                      input logic [7:0] mask);
        return (xy & mask) == (code & mask);
    endfunction

    always_comb begin
        vact   = (vs_q == vsync_pol);
        hact   = (hs_q == hsync_pol);
        vact_p = (vs_prev_q == vsync_pol);
        hact_p = (hs_prev_q == hsync_pol);
        byte_s = dat_q[7:0];
        is_ff  = (byte_s == 8'hFF);
        // cpos counts the bytes after an 0xFF marker; position 3 holds the XY code
        code_xy = embd_sync_en && (cpos_q == 2'd3);
        code_ok = code_xy && !cerr_q;
        hit_fs  = code_ok && code_hit(byte_s, fsc, fsu);
        hit_fe  = code_ok && !hit_fs && code_hit(byte_s, fec, feu);
        hit_ls  = code_ok && !hit_fs && !hit_fe && code_hit(byte_s, lsc, lsu);
        hit_le  = code_ok && !hit_fs && !hit_fe && !hit_ls && code_hit(byte_s, lec, leu);

        cpos_d = 2'd0;
        cerr_d = cerr_q;
        if (embd_sync_en) begin
            case (cpos_q)
                2'd0: cpos_d = is_ff ? 2'd1 : 2'd0;
                2'd1: begin cpos_d = 2'd2; cerr_d = (byte_s != 8'h00); end
                2'd2: begin cpos_d = 2'd3; cerr_d = cerr_q | (byte_s != 8'h00); end
                default: cpos_d = 2'd0;
            endcase
        end

        if (embd_sync_en) begin
            fs_ev   = hit_fs;
            fe_ev   = hit_fe;
            le_ev   = hit_le;
            pix_raw = inline_q && (cpos_q == 2'd0) && !is_ff;
        end else begin
            fs_ev   = vact && !vact_p;
            fe_ev   = !vact && vact_p;
            le_ev   = !hact && hact_p;
            pix_raw = vact && hact;
        end

        inline_d = inline_q;
        if (!embd_sync_en || !capture_en) inline_d = 1'b0;
        else if (hit_fs || hit_ls)        inline_d = 1'b1;
        else if (hit_le || hit_fe)        inline_d = 1'b0;

        in_frame = (state_q == FRAME);
        fe_now   = capture_en && in_frame && fe_ev;
        pix      = capture_en && pix_raw && !fe_now &&
                   (in_frame || ((state_q == WAIT_FS) && fs_ev));
    end

    // A completed word is held until the next pixel or frame end, so the
    // final word of a frame can be tagged with out_last.
    always_comb begin
        full   = (data_bus_width == 2'd0) ? (cnt_q == 3'd4) : (cnt_q == 3'd2);
        px16   = px_mask(16'(dat_q), data_bus_width);
        slot   = full ? 3'd0 : cnt_q;
        wbuf_d = wbuf_q;
        cnt_d  = cnt_q;
        ov_d   = 1'b0;
        od_d   = out_data;
        ol_d   = 1'b0;
        if (!capture_en) begin
            wbuf_d = 32'd0;
            cnt_d  = 3'd0;
        end else if (fe_now) begin
            if (cnt_q != 3'd0) begin
                ov_d = 1'b1;
                ol_d = 1'b1;
                od_d = wbuf_q;
            end
            wbuf_d = 32'd0;
            cnt_d  = 3'd0;
        end else if (pix) begin
            if (full) begin
                ov_d = 1'b1;
                od_d = wbuf_q;
            end
            wbuf_d = pack_px(full ? 32'd0 : wbuf_q, slot, px16, data_bus_width == 2'd0);
            cnt_d  = slot + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            vs_q           <= 1'b0;
            hs_q           <= 1'b0;
            vs_prev_q      <= 1'b0;
            hs_prev_q      <= 1'b0;
            dat_q          <= '0;
            cpos_q         <= 2'd0;
            cerr_q         <= 1'b0;
            inline_q       <= 1'b0;
            wbuf_q         <= 32'd0;
            cnt_q          <= 3'd0;
            out_valid      <= 1'b0;
            out_data       <= 32'd0;
            out_last       <= 1'b0;
            frame_start    <= 1'b0;
            frame_end      <= 1'b0;
            line_end       <= 1'b0;
            sync_err       <= 1'b0;
            capture_en_clr <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            vs_q           <= vsync;
            hs_q           <= hsync;
            dat_q          <= data;
            vs_prev_q      <= vs_q;
            hs_prev_q      <= hs_q;
            cpos_q         <= cpos_d;
            cerr_q         <= cerr_d;
            inline_q       <= inline_d;
            wbuf_q         <= wbuf_d;
            cnt_q          <= cnt_d;
            out_valid      <= ov_d;
            out_data       <= od_d;
            out_last       <= ol_d;
            frame_start    <= 1'b0;
            frame_end      <= 1'b0;
            line_end       <= 1'b0;
            capture_en_clr <= 1'b0;
            sync_err       <= capture_en && code_xy && cerr_q;
            if (!capture_en) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: state_q <= WAIT_FS;
                    WAIT_FS: begin
                        if (fs_ev) begin
                            state_q     <= FRAME;
                            frame_start <= 1'b1;
                        end
                    end
                    FRAME: begin
                        line_end <= le_ev;
                        if (fe_ev) begin
                            frame_end <= 1'b1;
                            frame_cnt <= frame_cnt + 1'b1;
                            if (snapshot_mode) begin
                                state_q        <= IDLE;
                                capture_en_clr <= 1'b1;
                            end else begin
                                state_q <= WAIT_FS;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dcmi_capture.sv
// Directed self-checking bench for dcmi_capture: external and embedded framing,
// packing, snapshot handshake, mid-frame enable/disable and asynchronous reset.
module tb_dcmi_capture;
    logic        clk = 1'b0;
    logic        rstn, capture_en, snapshot_mode, embd_sync_en, vsync_pol, hsync_pol;
    logic [1:0]  data_bus_width;
    logic [7:0]  fsc, fec, lsc, lec, fsu, feu, lsu, leu;
    logic        vsync, hsync;
    logic [13:0] data;
    logic        out_valid, out_last;
    logic [31:0] out_data;
    logic        frame_start, frame_end, line_end, sync_err, capture_en_clr;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [32:0] wq[$];
    int fs_n = 0, fe_n = 0, le_n = 0, se_n = 0, clr_n = 0, lfe_n = 0;
    logic [13:0] pix_tab [0:7];

    dcmi_capture #(.DW(14), .FCNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .capture_en(capture_en), .snapshot_mode(snapshot_mode),
        .embd_sync_en(embd_sync_en), .vsync_pol(vsync_pol), .hsync_pol(hsync_pol),
        .data_bus_width(data_bus_width),
        .fsc(fsc), .fec(fec), .lsc(lsc), .lec(lec),
        .fsu(fsu), .feu(feu), .lsu(lsu), .leu(leu),
        .vsync(vsync), .hsync(hsync), .data(data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .frame_start(frame_start), .frame_end(frame_end), .line_end(line_end),
        .sync_err(sync_err), .capture_en_clr(capture_en_clr), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) wq.push_back({out_last, out_data});
        if (frame_start) fs_n++;
        if (frame_end) fe_n++;
        if (line_end) le_n++;
        if (sync_err) se_n++;
        if (capture_en_clr) clr_n++;
        if (out_valid && out_last && frame_end) lfe_n++;
    end

    task automatic tick(input logic v, input logic h, input logic [13:0] d);
        @(posedge clk);
        #1;
        vsync = v;
        hsync = h;
        data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 1'b1, 14'h0);
    endtask

    task automatic ext_frame(input int lines, input int ppl);
        tick(1'b0, 1'b1, 14'h0);
        tick(1'b0, 1'b1, 14'h0);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < ppl; p++) tick(1'b0, 1'b0, pix_tab[l * ppl + p]);
            tick(1'b0, 1'b1, 14'h0);
            tick(1'b0, 1'b1, 14'h0);
        end
        tick(1'b1, 1'b1, 14'h0);
        idle(3);
    endtask

    task automatic eb(input logic [7:0] b);
        tick(1'b1, 1'b1, {6'h0, b});
    endtask

    task automatic ecode(input logic [7:0] xy, input logic [7:0] b2);
        eb(8'hFF);
        eb(b2);
        eb(8'h00);
        eb(xy);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++;
        if ({frame_start, frame_end, line_end, sync_err, capture_en_clr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 00000",
                     {frame_start, frame_end, line_end, sync_err, capture_en_clr});
        end
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_ext8_cont;
        int w0, fs0, fe0, le0, lfe0;
        logic [32:0] exp [0:3];
        exp = '{{1'b0, 32'h04030201}, {1'b1, 32'h08070605},
                {1'b0, 32'h04030201}, {1'b1, 32'h08070605}};
        for (int i = 0; i < 8; i++) pix_tab[i] = 14'(i + 1);
        w0 = wq.size(); fs0 = fs_n; fe0 = fe_n; le0 = le_n; lfe0 = lfe_n;
        capture_en = 1'b1;
        idle(4);
        ext_frame(2, 4);
        ext_frame(2, 4);
        checks++;
        if (wq.size() - w0 !== 4) begin errors++; $display("FAIL ext8_word_count got %0d want 4", wq.size() - w0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w0 + i >= wq.size() || wq[w0 + i] !== exp[i]) begin
                errors++;
                $display("FAIL ext8_word%0d got %h want %h", i,
                         (w0 + i < wq.size()) ? wq[w0 + i] : 33'h0, exp[i]);
            end
        end
        checks++;
        if (fs_n - fs0 !== 2) begin errors++; $display("FAIL ext8_frame_start got %0d want 2", fs_n - fs0); end
        checks++;
        if (fe_n - fe0 !== 2) begin errors++; $display("FAIL ext8_frame_end got %0d want 2", fe_n - fe0); end
        checks++;
        if (le_n - le0 !== 4) begin errors++; $display("FAIL ext8_line_end got %0d want 4", le_n - le0); end
        checks++;
        if (lfe_n - lfe0 !== 2) begin errors++; $display("FAIL ext8_last_with_fe got %0d want 2", lfe_n - lfe0); end
        checks++;
        if (frame_cnt !== 8'd2) begin errors++; $display("FAIL ext8_frame_cnt got %0d want 2", frame_cnt); end
    endtask

    task automatic test_ext12_snapshot;
        int w0, clr0;
        logic [32:0] exp [0:1];
        exp = '{{1'b0, 32'h01230ABC}, {1'b1, 32'h00000FFF}};
        capture_en = 1'b0;
        idle(2);
        data_bus_width = 2'd2;
        snapshot_mode  = 1'b1;
        pix_tab[0] = 14'hABC; pix_tab[1] = 14'h123; pix_tab[2] = 14'hFFF;
        w0 = wq.size(); clr0 = clr_n;
        capture_en = 1'b1;
        idle(3);
        ext_frame(1, 3);
        capture_en = 1'b0;
        checks++;
        if (wq.size() - w0 !== 2) begin errors++; $display("FAIL ext12_word_count got %0d want 2", wq.size() - w0); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (w0 + i >= wq.size() || wq[w0 + i] !== exp[i]) begin
                errors++;
                $display("FAIL ext12_word%0d got %h want %h", i,
                         (w0 + i < wq.size()) ? wq[w0 + i] : 33'h0, exp[i]);
            end
        end
        checks++;
        if (clr_n - clr0 !== 1) begin errors++; $display("FAIL ext12_capture_en_clr got %0d want 1", clr_n - clr0); end
        checks++;
        if (frame_cnt !== 8'd3) begin errors++; $display("FAIL ext12_frame_cnt got %0d want 3", frame_cnt); end
        idle(2);
    endtask

    task automatic test_mid_frame_enable;
        int w0, fs0, fe0, le0;
        snapshot_mode  = 1'b0;
        data_bus_width = 2'd0;
        w0 = wq.size(); fs0 = fs_n; fe0 = fe_n; le0 = le_n;
        tick(1'b0, 1'b1, 14'h0);
        tick(1'b0, 1'b1, 14'h0);
        tick(1'b0, 1'b0, 14'h11);
        tick(1'b0, 1'b0, 14'h12);
        capture_en = 1'b1;
        tick(1'b0, 1'b0, 14'h13);
        tick(1'b0, 1'b0, 14'h14);
        tick(1'b0, 1'b1, 14'h0);
        tick(1'b0, 1'b1, 14'h0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 14'(8'h15 + i));
        tick(1'b0, 1'b1, 14'h0);
        tick(1'b1, 1'b1, 14'h0);
        idle(3);
        for (int i = 0; i < 4; i++) pix_tab[i] = 14'(8'h21 + i);
        ext_frame(1, 4);
        checks++;
        if (wq.size() - w0 !== 1) begin errors++; $display("FAIL midfr_word_count got %0d want 1", wq.size() - w0); end
        checks++;
        if (w0 >= wq.size() || wq[w0] !== {1'b1, 32'h24232221}) begin
            errors++;
            $display("FAIL midfr_word got %h want 124232221", (w0 < wq.size()) ? wq[w0] : 33'h0);
        end
        checks++;
        if (fs_n - fs0 !== 1 || fe_n - fe0 !== 1) begin
            errors++;
            $display("FAIL midfr_fs_fe got %0d/%0d want 1/1", fs_n - fs0, fe_n - fe0);
        end
        checks++;
        if (le_n - le0 !== 1) begin errors++; $display("FAIL midfr_line_end got %0d want 1", le_n - le0); end
        checks++;
        if (frame_cnt !== 8'd4) begin errors++; $display("FAIL midfr_frame_cnt got %0d want 4", frame_cnt); end
    endtask

    task automatic test_embedded;
        int w0, fs0, fe0, le0, se0;
        capture_en = 1'b0;
        idle(2);
        embd_sync_en = 1'b1;
        w0 = wq.size(); fs0 = fs_n; fe0 = fe_n; le0 = le_n; se0 = se_n;
        capture_en = 1'b1;
        repeat (3) eb(8'h00);
        ecode(8'hAB, 8'h00);
        eb(8'h11); eb(8'h22);
        ecode(8'h9D, 8'h00);
        ecode(8'h85, 8'h00);
        eb(8'h33); eb(8'h44);
        ecode(8'h9D, 8'h00);
        ecode(8'hB6, 8'h00);
        repeat (3) eb(8'h00);
        checks++;
        if (wq.size() - w0 !== 1) begin errors++; $display("FAIL embd_word_count got %0d want 1", wq.size() - w0); end
        checks++;
        if (w0 >= wq.size() || wq[w0] !== {1'b1, 32'h44332211}) begin
            errors++;
            $display("FAIL embd_word got %h want 144332211", (w0 < wq.size()) ? wq[w0] : 33'h0);
        end
        checks++;
        if (le_n - le0 !== 2) begin errors++; $display("FAIL embd_line_end got %0d want 2", le_n - le0); end
        checks++;
        if (fs_n - fs0 !== 1 || fe_n - fe0 !== 1) begin
            errors++;
            $display("FAIL embd_fs_fe got %0d/%0d want 1/1", fs_n - fs0, fe_n - fe0);
        end
        checks++;
        if (se_n - se0 !== 0) begin errors++; $display("FAIL embd_sync_err got %0d want 0", se_n - se0); end
        checks++;
        if (frame_cnt !== 8'd5) begin errors++; $display("FAIL embd_frame_cnt got %0d want 5", frame_cnt); end
    endtask

    task automatic test_sync_err_drop;
        int w0, fs0, fe0, le0, se0;
        w0 = wq.size(); fs0 = fs_n; fe0 = fe_n; se0 = se_n;
        ecode(8'h80, 8'h01);
        repeat (3) eb(8'h00);
        checks++;
        if (se_n - se0 !== 1) begin errors++; $display("FAIL serr_pulse got %0d want 1", se_n - se0); end
        checks++;
        if (fs_n - fs0 !== 0 || wq.size() - w0 !== 0) begin
            errors++;
            $display("FAIL serr_no_events got fs=%0d words=%0d want 0/0", fs_n - fs0, wq.size() - w0);
        end
        fe0 = fe_n;
        ecode(8'hAB, 8'h00);
        eb(8'h55); eb(8'h66); eb(8'h77);
        capture_en = 1'b0;
        eb(8'h88);
        ecode(8'h9D, 8'h00);
        ecode(8'hB6, 8'h00);
        repeat (2) eb(8'h00);
        checks++;
        if (wq.size() - w0 !== 0 || fe_n - fe0 !== 0) begin
            errors++;
            $display("FAIL drop_no_output got words=%0d fe=%0d want 0/0", wq.size() - w0, fe_n - fe0);
        end
        w0 = wq.size(); fs0 = fs_n; fe0 = fe_n; le0 = le_n;
        capture_en = 1'b1;
        repeat (3) eb(8'h00);
        ecode(8'hAB, 8'h00);
        eb(8'h01); eb(8'h02); eb(8'h03);
        ecode(8'h9D, 8'h00);
        ecode(8'hB6, 8'h00);
        repeat (3) eb(8'h00);
        checks++;
        if (wq.size() - w0 !== 1) begin errors++; $display("FAIL drop_next_count got %0d want 1", wq.size() - w0); end
        checks++;
        if (w0 >= wq.size() || wq[w0] !== {1'b1, 32'h00030201}) begin
            errors++;
            $display("FAIL drop_next_word got %h want 100030201", (w0 < wq.size()) ? wq[w0] : 33'h0);
        end
        checks++;
        if (fs_n - fs0 !== 1 || fe_n - fe0 !== 1 || le_n - le0 !== 1) begin
            errors++;
            $display("FAIL drop_next_events got fs=%0d fe=%0d le=%0d want 1/1/1",
                     fs_n - fs0, fe_n - fe0, le_n - le0);
        end
        checks++;
        if (frame_cnt !== 8'd6) begin errors++; $display("FAIL drop_frame_cnt got %0d want 6", frame_cnt); end
    endtask

    task automatic test_async_reset;
        int w0, fe0;
        capture_en = 1'b0;
        idle(2);
        embd_sync_en = 1'b0;
        capture_en   = 1'b1;
        idle(3);
        tick(1'b0, 1'b1, 14'h0);
        tick(1'b0, 1'b1, 14'h0);
        tick(1'b0, 1'b0, 14'h01);
        tick(1'b0, 1'b0, 14'h02);
        tick(1'b0, 1'b0, 14'h03);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL areset_frame_cnt got %0d want 0", frame_cnt); end
        checks++;
        if (out_data !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_out got valid=%b data=%h want 0/00000000", out_valid, out_data);
        end
        tick(1'b0, 1'b0, 14'h04);
        tick(1'b0, 1'b0, 14'h05);
        rstn = 1'b1;
        w0 = wq.size(); fe0 = fe_n;
        tick(1'b0, 1'b0, 14'h06);
        tick(1'b0, 1'b1, 14'h0);
        tick(1'b1, 1'b1, 14'h0);
        idle(3);
        for (int i = 0; i < 4; i++) pix_tab[i] = 14'(8'h31 + i);
        ext_frame(1, 4);
        checks++;
        if (wq.size() - w0 !== 1) begin errors++; $display("FAIL areset_word_count got %0d want 1", wq.size() - w0); end
        checks++;
        if (w0 >= wq.size() || wq[w0] !== {1'b1, 32'h34333231}) begin
            errors++;
            $display("FAIL areset_word got %h want 134333231", (w0 < wq.size()) ? wq[w0] : 33'h0);
        end
        checks++;
        if (fe_n - fe0 !== 1 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL areset_after got fe=%0d cnt=%0d want 1/1", fe_n - fe0, frame_cnt);
        end
    endtask

    initial begin
        rstn = 1'b0; capture_en = 1'b0; snapshot_mode = 1'b0; embd_sync_en = 1'b0;
        vsync_pol = 1'b0; hsync_pol = 1'b0; data_bus_width = 2'd0;
        fsc = 8'hAB; fec = 8'hB6; lsc = 8'h80; lec = 8'h9D;
        fsu = 8'hFF; feu = 8'hFF; lsu = 8'hF0; leu = 8'hFF;
        vsync = 1'b1; hsync = 1'b1; data = 14'h0;
        test_reset;
        test_ext8_cont;
        test_ext12_snapshot;
        test_mid_frame_enable;
        test_embedded;
        test_sync_err_drop;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
